// File: rtl/dp_pkg.sv
// ============================================================================
// dp_pkg -- opcodes, FSM state type and flag bit positions for param_datapath
// Rev 1.0
// ============================================================================
`default_nettype none

package dp_pkg;

  localparam logic [3:0] OP_ADD = 4'h0;
  localparam logic [3:0] OP_SUB = 4'h1;
  localparam logic [3:0] OP_AND = 4'h2;
  localparam logic [3:0] OP_OR  = 4'h3;
  localparam logic [3:0] OP_XOR = 4'h4;
  localparam logic [3:0] OP_CMP = 4'h5;
  localparam logic [3:0] OP_MOV = 4'h6;
  localparam logic [3:0] OP_RSV = 4'h7;
  localparam logic [3:0] OP_SLL = 4'h8;
  localparam logic [3:0] OP_SLR = 4'h9;
  localparam logic [3:0] OP_SRL = 4'hA;
  localparam logic [3:0] OP_SRA = 4'hB;
  localparam logic [3:0] OP_LI  = 4'hC;
  localparam logic [3:0] OP_IN  = 4'hD;
  localparam logic [3:0] OP_OUT = 4'hE;
  localparam logic [3:0] OP_NOP = 4'hF;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_WB   = 2'd2
  } state_t;

  localparam int FLAG_S = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

endpackage

`default_nettype wire

// File: rtl/dp_alu.sv
// ============================================================================
// dp_alu -- combinational ALU/shifter producing result, SZCV and enables
// Rev 1.0
// ============================================================================
`default_nettype none

module dp_alu
  import dp_pkg::*;
#(
  parameter int W = 16
) (
  input  logic [W-1:0]         a,
  input  logic [W-1:0]         b,
  input  logic [3:0]           op,
  input  logic [$clog2(W)-1:0] shamt,
  output logic [W-1:0]         res,
  output logic [3:0]           szcv,
  output logic                 wr_en,
  output logic                 fl_en
);

  localparam int SW = $clog2(W);

  // Guard bit on each side of the shifts captures the last bit shifted out
  logic [W:0]        w_sum;
  logic [W:0]        w_diff;
  logic [W:0]        w_shl;
  logic [W:0]        w_shr;
  logic signed [W:0] w_sra;
  logic [SW:0]       w_ramt;
  logic [W-1:0]      w_rot;
  logic              w_c;
  logic              w_v;

  assign w_sum  = {1'b0, a} + {1'b0, b};
  assign w_diff = {1'b0, a} - {1'b0, b};
  assign w_shl  = {1'b0, b} << shamt;
  assign w_shr  = {b, 1'b0} >> shamt;
  assign w_sra  = $signed({b, 1'b0}) >>> shamt;
  assign w_ramt = (SW + 1)'(W) - {1'b0, shamt};
  assign w_rot  = (b << shamt) | (b >> w_ramt);

  always_comb begin
    res   = '0;
    w_c   = 1'b0;
    w_v   = 1'b0;
    wr_en = 1'b1;
    fl_en = 1'b1;
    case (op)
      OP_ADD: begin
        res = w_sum[W-1:0];
        w_c = w_sum[W];
        w_v = (a[W-1] == b[W-1]) && (res[W-1] != a[W-1]);
      end
      OP_SUB, OP_CMP: begin
        res   = w_diff[W-1:0];
        w_c   = w_diff[W];
        w_v   = (a[W-1] != b[W-1]) && (res[W-1] != a[W-1]);
        wr_en = (op == OP_SUB);
      end
      OP_AND: res = a & b;
      OP_OR:  res = a | b;
      OP_XOR: res = a ^ b;
      OP_SLL: begin
        res = w_shl[W-1:0];
        w_c = w_shl[W];
      end
      OP_SLR: begin
        res = w_rot;
        w_c = (shamt != '0) && w_rot[0];
      end
      OP_SRL: begin
        res = w_shr[W:1];
        w_c = w_shr[0];
      end
      OP_SRA: begin
        res = w_sra[W:1];
        w_c = w_sra[0];
      end
      OP_MOV: begin
        res   = a;
        fl_en = 1'b0;
      end
      OP_LI: begin
        res   = b;
        fl_en = 1'b0;
      end
      OP_IN: fl_en = 1'b0;
      default: begin
        wr_en = 1'b0;
        fl_en = 1'b0;
      end
    endcase
  end

  always_comb begin
    szcv         = '0;
    szcv[FLAG_S] = res[W-1];
    szcv[FLAG_Z] = (res == '0);
    szcv[FLAG_C] = w_c;
    szcv[FLAG_V] = w_v;
  end

endmodule

`default_nettype wire

// File: rtl/param_datapath.sv
// ============================================================================
// param_datapath -- multicycle N x W register-file datapath, IDLE->EXEC->WB
// Rev 1.0
// ============================================================================
`default_nettype none

module param_datapath
  import dp_pkg::*;
#(
  parameter int W    = 16,
  parameter int N    = 8,
  parameter int IMMW = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 instr_valid,
  output logic                 instr_ready,
  input  logic [3:0]           op,
  input  logic [$clog2(N)-1:0] rd_idx,
  input  logic [$clog2(N)-1:0] ra_idx,
  input  logic [$clog2(N)-1:0] rb_idx,
  input  logic [IMMW-1:0]      immd,
  input  logic                 in_valid,
  input  logic [W-1:0]         data_in,
  output logic [W-1:0]         data_out,
  output logic                 out_valid,
  output logic [3:0]           flags,
  input  logic [$clog2(N)-1:0] dbg_idx,
  output logic [W-1:0]         dbg_data
);

  localparam int RW = $clog2(N);
  localparam int SW = $clog2(W);

  state_t          r_state;
  logic [3:0]      r_op;
  logic [RW-1:0]   r_rd;
  logic [IMMW-1:0] r_imm;
  logic [W-1:0]    r_a;
  logic [W-1:0]    r_b;
  logic [W-1:0]    r_res;
  logic [3:0]      r_szcv;
  logic            r_wr;
  logic            r_fl;
  logic [W-1:0]    r_regs [N];
  logic [3:0]      r_flags;
  logic [W-1:0]    r_dout;
  logic            r_ov;

  logic [W-1:0]    w_alu_b;
  logic [W-1:0]    w_res;
  logic [3:0]      w_szcv;
  logic            w_wr;
  logic            w_fl;

  // LI reuses the B path to carry the zero-extended immediate
  assign w_alu_b = (r_op == OP_LI) ? W'(r_imm) : r_b;

  dp_alu #(.W(W)) u_alu (
    .a     (r_a),
    .b     (w_alu_b),
    .op    (r_op),
    .shamt (r_imm[SW-1:0]),
    .res   (w_res),
    .szcv  (w_szcv),
    .wr_en (w_wr),
    .fl_en (w_fl)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_op    <= OP_NOP;
      r_rd    <= '0;
      r_imm   <= '0;
      r_a     <= '0;
      r_b     <= '0;
      r_res   <= '0;
      r_szcv  <= '0;
      r_wr    <= 1'b0;
      r_fl    <= 1'b0;
      r_flags <= '0;
      r_dout  <= '0;
      r_ov    <= 1'b0;
      for (int i = 0; i < N; i++) r_regs[i] <= '0;
    end else begin
      r_ov <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (instr_valid) begin
            r_op    <= op;
            r_rd    <= rd_idx;
            r_imm   <= immd;
            r_a     <= r_regs[ra_idx];
            r_b     <= r_regs[rb_idx];
            r_state <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          // IN parks here until the external producer offers data
          if ((r_op != OP_IN) || in_valid) begin
            r_res   <= (r_op == OP_IN) ? data_in : w_res;
            r_szcv  <= w_szcv;
            r_wr    <= w_wr;
            r_fl    <= w_fl;
            r_state <= ST_WB;
          end
        end
        ST_WB: begin
          if (r_wr) r_regs[r_rd] <= r_res;
          if (r_fl) r_flags <= r_szcv;
          if (r_op == OP_OUT) begin
            r_dout <= r_b;
            r_ov   <= 1'b1;
          end
          r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign instr_ready = (r_state == ST_IDLE);
  assign data_out    = r_dout;
  assign out_valid   = r_ov;
  assign flags       = r_flags;
  assign dbg_data    = r_regs[dbg_idx];

endmodule

`default_nettype wire

// File: tb/tb_param_datapath.sv
// ============================================================================
// tb_param_datapath -- directed + randomized bench with behavioural model
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_param_datapath;
  import dp_pkg::*;

  localparam int W    = 16;
  localparam int N    = 8;
  localparam int IMMW = 8;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        instr_valid = 1'b0;
  logic        instr_ready;
  logic [3:0]  op = 4'h0;
  logic [2:0]  rd_idx = '0, ra_idx = '0, rb_idx = '0, dbg_idx = '0;
  logic [7:0]  immd = '0;
  logic        in_valid = 1'b0;
  logic [15:0] data_in = '0;
  logic [15:0] data_out, dbg_data;
  logic        out_valid;
  logic [3:0]  flags;

  always #5 clk = ~clk;

  param_datapath #(.W(W), .N(N), .IMMW(IMMW)) dut (
    .clk(clk), .reset(reset), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .op(op), .rd_idx(rd_idx), .ra_idx(ra_idx), .rb_idx(rb_idx), .immd(immd),
    .in_valid(in_valid), .data_in(data_in), .data_out(data_out), .out_valid(out_valid),
    .flags(flags), .dbg_idx(dbg_idx), .dbg_data(dbg_data)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Architectural state expected to be visible on the outputs right now
  logic [15:0] m_regs [N];
  logic [3:0]  m_flags = '0;
  logic [15:0] m_dout  = '0;
  logic        m_ov    = 1'b0;
  logic        m_ready = 1'b1;
  logic        m_en    = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Returns {wr, fl, S, Z, C, V, res[15:0]} from the instruction semantics
  function automatic logic [21:0] model(input logic [3:0] o, input logic [15:0] a,
                                        input logic [15:0] b, input logic [7:0] imm);
    int unsigned ua, ub, r;
    int sa, sb, sv, sh;
    logic c, v, wr, fl;
    logic [15:0] res;
    ua = 32'(a); ub = 32'(b);
    sa = int'($signed(a)); sb = int'($signed(b));
    sh = int'(imm[3:0]);
    r = 0; c = 0; v = 0; wr = 1; fl = 1;
    case (o)
      4'h0: begin r = ua + ub; c = r[16]; sv = sa + sb; v = (sv > 32767) || (sv < -32768); end
      4'h1, 4'h5: begin
        r = ua - ub; c = (ua < ub); sv = sa - sb; v = (sv > 32767) || (sv < -32768);
        wr = (o == 4'h1);
      end
      4'h2: r = ua & ub;
      4'h3: r = ua | ub;
      4'h4: r = ua ^ ub;
      4'h6: begin r = ua; fl = 0; end
      4'h8: begin r = ub << sh; c = (sh != 0) && (((ub >> (16 - sh)) & 1) != 0); end
      4'h9: begin r = (ub << sh) | (ub >> (16 - sh)); c = (sh != 0) && ((r & 1) != 0); end
      4'hA: begin r = ub >> sh; c = (sh != 0) && (((ub >> (sh - 1)) & 1) != 0); end
      4'hB: begin r = unsigned'(sb >>> sh); c = (sh != 0) && (((sb >>> (sh - 1)) & 1) != 0); end
      4'hC: begin r = 32'(imm); fl = 0; end
      4'hD: fl = 0;
      default: begin wr = 0; fl = 0; end
    endcase
    res = r[15:0];
    return {wr, fl, res[15], (res == 16'h0), c, v, res};
  endfunction

  always @(negedge clk) begin
    if (m_en) begin
      chk("flags", 32'(flags), 32'(m_flags));
      chk("data_out", 32'(data_out), 32'(m_dout));
      chk("out_valid", 32'(out_valid), 32'(m_ov));
      chk("instr_ready", 32'(instr_ready), 32'(m_ready));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    m_ov = 1'b0;
  endtask

  task automatic do_instr(input logic [3:0] o, input int rd, input int ra, input int rb,
                          input logic [7:0] imm, input logic [15:0] din, input int stall);
    logic [21:0] e;
    logic [15:0] bv, res;
    instr_valid = 1'b1; op = o; immd = imm; in_valid = 1'b0;
    rd_idx = 3'(rd); ra_idx = 3'(ra); rb_idx = 3'(rb);
    tick();
    e  = model(o, m_regs[ra], m_regs[rb], imm);
    bv = m_regs[rb];
    m_ready = 1'b0;
    instr_valid = 1'b0;
    op = 4'($urandom); immd = 8'($urandom);
    rd_idx = 3'($urandom); ra_idx = 3'($urandom); rb_idx = 3'($urandom);
    if (o == OP_IN) begin
      for (int i = 0; i < stall; i++) begin
        data_in = 16'($urandom);
        tick();
        dbg_idx = 3'(rd);
        #1 chk("stall_nowrite", 32'(dbg_data), 32'(m_regs[rd]));
      end
      in_valid = 1'b1; data_in = din;
      tick();
      in_valid = 1'b0; data_in = 16'($urandom);
      res = din;
    end else begin
      in_valid = 1'($urandom); data_in = 16'($urandom);
      tick();
      in_valid = 1'b0;
      res = e[15:0];
    end
    tick();
    if (e[21]) m_regs[rd] = res;
    if (e[20]) m_flags = e[19:16];
    if (o == OP_OUT) begin
      m_dout = bv;
      m_ov   = 1'b1;
    end
    m_ready = 1'b1;
  endtask

  task automatic check_reg(input int idx, input logic [15:0] exp, input string name);
    dbg_idx = 3'(idx);
    #1 chk(name, 32'(dbg_data), 32'(exp));
  endtask

  initial begin
    logic [3:0] ro;
    logic [7:0] rimm;
    for (int i = 0; i < N; i++) m_regs[i] = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    m_en = 1'b1;

    for (int i = 0; i < N; i++) check_reg(i, 16'h0, "reset_reg");
    chk("reset_flags", 32'(flags), 32'h0);
    chk("reset_dout", 32'(data_out), 32'h0);
    chk("reset_ready", 32'(instr_ready), 32'h1);

    do_instr(OP_IN, 1, 0, 0, 8'h00, 16'h7FFF, 0);
    check_reg(1, 16'h7FFF, "in_r1");
    do_instr(OP_LI, 2, 0, 0, 8'h01, 16'h0, 0);
    check_reg(2, 16'h0001, "li_r2");
    do_instr(OP_ADD, 3, 1, 2, 8'h00, 16'h0, 0);
    check_reg(3, 16'h8000, "add_r3");
    chk("add_flags", 32'(flags), 32'b1001);
    do_instr(OP_SUB, 4, 2, 1, 8'h00, 16'h0, 0);
    check_reg(4, 16'h8002, "sub_r4");
    chk("sub_flags", 32'(flags), 32'b1010);
    do_instr(OP_CMP, 0, 1, 1, 8'h00, 16'h0, 0);
    chk("cmp_flags", 32'(flags), 32'b0100);
    check_reg(1, 16'h7FFF, "cmp_r1");
    do_instr(OP_SRA, 5, 0, 3, 8'h04, 16'h0, 0);
    check_reg(5, 16'hF800, "sra_r5");
    chk("sra_flags", 32'(flags), 32'b1000);
    do_instr(OP_SLL, 6, 0, 3, 8'h01, 16'h0, 0);
    check_reg(6, 16'h0000, "sll_r6");
    chk("sll_flags", 32'(flags), 32'b0110);
    do_instr(OP_SLR, 6, 0, 3, 8'h01, 16'h0, 0);
    check_reg(6, 16'h0001, "slr_r6");
    chk("slr_flags", 32'(flags), 32'b0010);
    do_instr(OP_IN, 7, 0, 0, 8'h00, 16'h1234, 5);
    check_reg(7, 16'h1234, "in_r7");
    do_instr(OP_OUT, 0, 0, 3, 8'h00, 16'h0, 0);
    chk("out_data", 32'(data_out), 32'h8000);
    chk("out_pulse", 32'(out_valid), 32'h1);
    chk("out_flags", 32'(flags), 32'b0010);
    tick();
    chk("out_pulse_end", 32'(out_valid), 32'h0);
    do_instr(OP_ADD, 1, 1, 1, 8'h00, 16'h0, 0);
    check_reg(1, 16'hFFFE, "add_same");
    chk("add_same_flags", 32'(flags), 32'b1001);

    // Abort an ADD r0 while it sits in EXEC
    instr_valid = 1'b1; op = OP_ADD; rd_idx = 3'd0; ra_idx = 3'd1; rb_idx = 3'd1;
    tick();
    instr_valid = 1'b0; m_ready = 1'b0;
    reset = 1'b1;
    tick();
    for (int i = 0; i < N; i++) m_regs[i] = '0;
    m_flags = '0; m_dout = '0; m_ready = 1'b1;
    reset = 1'b0;
    tick(); tick();
    check_reg(0, 16'h0, "abort_r0");
    chk("abort_flags", 32'(flags), 32'h0);
    chk("abort_ready", 32'(instr_ready), 32'h1);

    for (int k = 0; k < 200; k++) begin
      ro   = 4'($urandom_range(0, 15));
      rimm = 8'($urandom);
      if (ro == OP_SLR && rimm[3:0] == 4'h0) rimm[0] = 1'b1;
      do_instr(ro, int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
               int'($urandom_range(0, 7)), rimm, 16'($urandom), int'($urandom_range(0, 3)));
      for (int i = 0; i < N; i++) check_reg(i, m_regs[i], "rand_reg");
      if ($urandom_range(0, 3) == 0) tick();
    end

    tick();
    m_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
